rgb_pwm_fader: RTL
==================

# rgb_pwm_fader

Parametrised multi-channel PWM LED driver for the UPduino RGB outputs. It generalises the fixed three-LED pattern generator to CHANNELS independent PWM outputs of PWM_BITS resolution. Each channel supports four modes: off, static, breathing (triangle fade) and blink. Channels are configured through a valid/ready write port, and new settings take effect glitch-free at the next PWM period boundary. It sits between the design's control logic and the RGB pad driver.

## Interface
- CHANNELS, 3: number of PWM outputs (≥1).
- PWM_BITS, 8: duty/counter resolution; PWM period = 2^PWM_BITS ticks.
- PRESCALE, 390: clk cycles per PWM tick (≥1).
- FADE_DIV, 4: PWM periods per fade/blink step (≥1).
- CW, $clog2(CHANNELS) (min 1): derived width of cfg_chan.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  write slot free; a write is accepted when cfg_valid & cfg_ready.
- cfg_chan  in  CW  target channel.
- cfg_mode  in  2  mode: 0 OFF, 1 STATIC, 2 BREATHE, 3 BLINK.
- cfg_level  in  PWM_BITS  target/peak duty.
- led_out  out  CHANNELS  registered PWM outputs, active-high.
- period_start  out  1  one-cycle pulse on each PWM period boundary.

## Operation
- Prescaler counts 0..PRESCALE-1. `tick` = prescaler at PRESCALE-1.
- pwm_cnt (PWM_BITS) increments on tick and wraps at all-ones to 0.
- Boundary = tick & pwm_cnt all-ones. period_start is registered and asserted the cycle after the boundary.
- Per channel state: mode, level, duty, dir (1 = up), fade_cnt (0..FADE_DIV-1).
- led_out[i] <= (pwm_cnt < duty[i]), evaluated every clk.
  - duty 0: output constantly low.
  - duty all-ones: output high for 2^PWM_BITS−1 of every 2^PWM_BITS ticks.
- Config path: single pending slot.
  - Accept sets `pending` and captures chan/mode/level. cfg_ready = ~pending & ~rst.
  - At the next boundary the pending write is applied and pending clears.
  - A write accepted in the same cycle as a boundary waits for the following boundary.
  - A write with cfg_chan ≥ CHANNELS is accepted, then discarded at the boundary.
- Apply sets mode and level, clears fade_cnt, and sets duty/dir:
  - OFF: duty 0.
  - STATIC: duty = level.
  - BREATHE: duty 0, dir up.
  - BLINK: duty = level.
- Fade engine, at each boundary for channels not being written:
  - fade_cnt increments. When it equals FADE_DIV-1 it wraps to 0 and a step occurs.
  - BREATHE step, dir up: if duty == level, dir <= down; else duty+1.
  - BREATHE step, dir down: if duty == 0, dir <= up; else duty−1.
  - Both endpoints are held for one extra step. Full cycle = 2·(level+1) steps.
  - BLINK step: duty toggles between level and 0.
  - OFF and STATIC: duty is unchanged.
- Config apply and a fade step on the same channel at the same boundary: the apply wins.
- Duty only changes at boundaries, so no partial or runt pulses occur.

## Timing
- Reset (rst high at a clk edge) clears:
  - prescaler, pwm_cnt, pending, all mode/level/duty/fade_cnt → 0; dir → up.
  - led_out → 0, period_start → 0.
- cfg_ready is 0 while rst is high and 1 on the first cycle after release.
- First boundary falls on cycle PRESCALE·2^PWM_BITS − 1 after release (cycle 0 = first cycle with rst low). period_start follows one cycle later.
- Config latency: accept → applied at next boundary → reflected in led_out one cycle later.
- Reset mid-operation drops any pending write; outputs are low from the cycle after the reset edge.
- All outputs are registered; there are no combinational paths from inputs to outputs except cfg_ready from rst.

## Test plan
All scenarios use PRESCALE=2, PWM_BITS=4, FADE_DIV=2, giving a 32-clk period.
- Reset release:
  - led_out=000 and cfg_ready=1 on the first cycle after release.
  - First boundary at cycle 31, period_start high at cycle 32, then repeating every 32 clk.
- STATIC ch0, level 4:
  - After the next boundary, led_out[0] is high exactly 8 clk of every 32.
  - ch1 and ch2 stay low.
- Handshake:
  - Two back-to-back writes. cfg_ready drops after the first accept; the second is stalled until the boundary.
  - The second write is applied one period later; cfg_ready returns to 1.
- BREATHE ch1, level 3:
  - Per-step duty sequence 0,1,2,3,3,2,1,0,0,1…
  - Each step lasts 2 periods; high-time per period equals 2·duty clk.
- BLINK ch2, level 15, plus a write to cfg_chan=3:
  - led_out[2] alternates 30/32 clk high for 2 periods, then 0 for 2 periods.
  - The chan 3 write changes nothing.
- Mid-operation reset while a write is pending:
  - led_out=000 from the next cycle.
  - After release, no channel reflects the dropped write.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED driver with per-channel off/static/breathe/blink modes.
// Config writes are staged in a single slot and applied on PWM period boundaries.
module rgb_pwm_fader #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 390,
    parameter int FADE_DIV = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    output logic [CHANNELS-1:0] led_out,
    output logic                period_start
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick, boundary, accept;

    logic                pend_q, pend_d;
    logic [CW-1:0]       pchan_q, pchan_d;
    mode_e               pmode_q, pmode_d;
    logic [PWM_BITS-1:0] plevel_q, plevel_d;

    mode_e               mode_q  [CHANNELS];
    mode_e               mode_d  [CHANNELS];
    logic [PWM_BITS-1:0] level_q [CHANNELS];
    logic [PWM_BITS-1:0] level_d [CHANNELS];
    logic [PWM_BITS-1:0] duty_q  [CHANNELS];
    logic [PWM_BITS-1:0] duty_d  [CHANNELS];
    logic                dir_q   [CHANNELS];
    logic                dir_d   [CHANNELS];
    logic [FW-1:0]       fade_q  [CHANNELS];
    logic [FW-1:0]       fade_d  [CHANNELS];

    logic [CHANNELS-1:0] led_q, led_d;
    logic                pstart_q;

    assign cfg_ready    = ~pend_q & ~rst;
    assign led_out      = led_q;
    assign period_start = pstart_q;

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick & (&pwm_q);
        accept   = cfg_valid & cfg_ready;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        pwm_d    = tick ? pwm_q + PWM_BITS'(1) : pwm_q;

        pend_d   = pend_q;
        pchan_d  = pchan_q;
        pmode_d  = pmode_q;
        plevel_d = plevel_q;
        if (boundary) begin
            pend_d = 1'b0;
        end
        // accept only happens with the slot empty, so it never races the clear
        if (accept) begin
            pend_d   = 1'b1;
            pchan_d  = cfg_chan;
            pmode_d  = mode_e'(cfg_mode);
            plevel_d = cfg_level;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]  = mode_q[i];
            level_d[i] = level_q[i];
            duty_d[i]  = duty_q[i];
            dir_d[i]   = dir_q[i];
            fade_d[i]  = fade_q[i];
            led_d[i]   = (pwm_q < duty_q[i]);
            if (boundary) begin
                if (pend_q && (int'(pchan_q) == i)) begin
                    mode_d[i]  = pmode_q;
                    level_d[i] = plevel_q;
                    fade_d[i]  = '0;
                    dir_d[i]   = 1'b1;
                    duty_d[i]  = (pmode_q == MODE_STATIC || pmode_q == MODE_BLINK) ? plevel_q : '0;
                end else if (fade_q[i] != FADE_LAST) begin
                    fade_d[i] = fade_q[i] + FW'(1);
                end else begin
                    fade_d[i] = '0;
                    // endpoints are held one extra step by turning instead of moving
                    case (mode_q[i])
                        MODE_BREATHE: begin
                            if (dir_q[i]) begin
                                if (duty_q[i] == level_q[i]) dir_d[i] = 1'b0;
                                else                         duty_d[i] = duty_q[i] + PWM_BITS'(1);
                            end else begin
                                if (duty_q[i] == '0) dir_d[i] = 1'b1;
                                else                 duty_d[i] = duty_q[i] - PWM_BITS'(1);
                            end
                        end
                        MODE_BLINK: duty_d[i] = (duty_q[i] != '0) ? '0 : level_q[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            pwm_q    <= '0;
            pend_q   <= 1'b0;
            pchan_q  <= '0;
            pmode_q  <= MODE_OFF;
            plevel_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= MODE_OFF;
                level_q[i] <= '0;
                duty_q[i]  <= '0;
                dir_q[i]   <= 1'b1;
                fade_q[i]  <= '0;
            end
            led_q    <= '0;
            pstart_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            pend_q   <= pend_d;
            pchan_q  <= pchan_d;
            pmode_q  <= pmode_d;
            plevel_q <= plevel_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= mode_d[i];
                level_q[i] <= level_d[i];
                duty_q[i]  <= duty_d[i];
                dir_q[i]   <= dir_d[i];
                fade_q[i]  <= fade_d[i];
            end
            led_q    <= led_d;
            pstart_q <= boundary;
        end
    end

endmodule
